ieee_norm_ctrl: RTL and testbench

Post-add normalization sequencer for the sequential IEEE-754 single-precision adder. It accepts the raw 25-bit magnitude sum (carry bit plus hidden bit plus fraction), the tentative biased exponent and the sign. It then sequences leading-zero counting and shifting over several cycles, and returns a normalized or denormal result with status flags. It sits between the adder's add/subtract stage and the packing stage, using a valid/ready handshake on both sides.

---
 rtl/ieee_norm_ctrl_pkg.sv | 17 +
 rtl/ieee_norm_ctrl_if.sv | 33 +++
 rtl/ieee_norm_ctrl_lzc24.sv | 15 +
 rtl/ieee_norm_ctrl.sv | 149 ++++++++++++++
 tb/tb_ieee_norm_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/ieee_norm_ctrl_pkg.sv
// Shared types and constants for the post-add normalization sequencer.
package norm_pkg;

  localparam int unsigned MANT_W  = 24;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam logic [8:0]  EXP_MAX = 9'd255;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    COUNT,
    SHIFT,
    DONE
  } norm_state_t;

endpackage

// File: rtl/ieee_norm_ctrl_if.sv
// Handshake/data bundle between the add stage, the normalizer and the packer.
// slave: the normalizer's view; master: the surrounding pipeline's view.
interface ieee_norm_ctrl_if;
  import norm_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [MANT_W:0]       in_mant;
  logic [EXP_W-1:0]      in_exp;
  logic                  in_sign;

  logic                  out_valid;
  logic                  out_ready;
  logic [FRAC_W-1:0]     out_frac;
  logic [EXP_W-1:0]      out_exp;
  logic                  out_sign;
  logic                  out_zero;
  logic                  out_ovf;
  logic                  out_uf;

  modport slave (
    input  in_valid, in_mant, in_exp, in_sign, out_ready,
    output in_ready, out_valid, out_frac, out_exp, out_sign,
           out_zero, out_ovf, out_uf
  );

  modport master (
    output in_valid, in_mant, in_exp, in_sign, out_ready,
    input  in_ready, out_valid, out_frac, out_exp, out_sign,
           out_zero, out_ovf, out_uf
  );

endinterface

// File: rtl/ieee_norm_ctrl_lzc24.sv
// Combinational 24-bit leading-zero counter; all-zero input reports 23.
module lzc24 (
  input  logic [23:0] i_data,
  output logic [4:0]  o_count
);

  // Scan upward so the highest set bit determines the count.
  always_comb begin
    o_count = 5'd23;
    for (int unsigned i = 0; i < 24; i++) begin
      if (i_data[i]) o_count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/ieee_norm_ctrl.sv
// Post-add normalization sequencer for the sequential single-precision adder.
// Optional feature macro: NORM_DENORM_EN (defined: underflow yields a denormal,
// undefined: underflow flushes to signed zero).
module ieee_norm_ctrl #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 8
) (
  input logic              clk,
  input logic              rst,
  ieee_norm_ctrl_if.slave  bus
);
  import norm_pkg::*;

  norm_state_t       r_state;
  norm_state_t       w_next;

  logic [MANT_W:0]   r_mant;
  logic [EXP_W:0]    r_exp;
  logic              r_sign;
  logic [4:0]        r_cnt;
  logic              r_zero;
  logic              r_ovf;
  logic              r_uf;

  logic              w_accept;
  logic [4:0]        w_lzc;
  logic [EXP_W:0]    w_exp_inc;
  logic [EXP_W:0]    w_exp_sub;
  logic              w_norm_ok;
  logic [MANT_W-1:0] w_sh_norm;
  logic              w_early;

  assign w_accept  = bus.in_valid && (r_state == IDLE);
  assign w_exp_inc = r_exp + 1'b1;
  assign w_exp_sub = r_exp - (EXP_W+1)'(r_cnt);
  // 9-bit difference: no borrow and non-zero means exp_r > cnt_r.
  assign w_norm_ok = !w_exp_sub[EXP_W] && (w_exp_sub != '0);
  assign w_sh_norm = r_mant[MANT_W-1:0] << r_cnt;
  assign w_early   = (r_exp == EXP_MAX) || r_mant[MANT_W] ||
                     (r_mant[MANT_W-1:0] == '0) || r_mant[MANT_W-1];

`ifdef NORM_DENORM_EN
  logic [4:0]        w_den_amt;
  logic [MANT_W-1:0] w_sh_den;
  assign w_den_amt = r_exp[4:0] - 5'd1;
  assign w_sh_den  = r_mant[MANT_W-1:0] << w_den_amt;
`endif

  lzc24 u_lzc (
    .i_data  (r_mant[MANT_W-1:0]),
    .o_count (w_lzc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_accept) w_next = EVAL;
      EVAL:  w_next = w_early ? DONE : COUNT;
      COUNT: w_next = SHIFT;
      SHIFT: w_next = DONE;
      DONE:  if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
  end

  // Operand capture and per-state datapath updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mant <= '0;
      r_exp  <= '0;
      r_sign <= 1'b0;
      r_cnt  <= '0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
      r_uf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_mant <= bus.in_mant;
          r_exp  <= {1'b0, bus.in_exp};
          r_sign <= bus.in_sign;
          r_cnt  <= '0;
          r_zero <= 1'b0;
          r_ovf  <= 1'b0;
          r_uf   <= 1'b0;
        end
        EVAL: begin
          if (r_exp == EXP_MAX) begin
            // Infinity/NaN exponent: leave operands untouched.
          end else if (r_mant[MANT_W]) begin
            r_exp <= w_exp_inc;
            if (w_exp_inc == EXP_MAX) begin
              r_mant <= '0;
              r_ovf  <= 1'b1;
            end else begin
              r_mant <= r_mant >> 1;
            end
          end else if (r_mant[MANT_W-1:0] == '0) begin
            r_exp  <= '0;
            r_zero <= 1'b1;
          end
        end
        COUNT: r_cnt <= w_lzc;
        SHIFT: begin
          if (w_norm_ok) begin
            r_mant <= {1'b0, w_sh_norm};
            r_exp  <= w_exp_sub;
          end else if (r_exp == '0) begin
            r_uf <= 1'b1;
          end else begin
`ifdef NORM_DENORM_EN
            r_mant <= {1'b0, w_sh_den};
            r_exp  <= '0;
            r_uf   <= 1'b1;
            r_zero <= (w_sh_den[FRAC_W-1:0] == '0);
`else
            r_mant <= '0;
            r_exp  <= '0;
            r_uf   <= 1'b1;
            r_zero <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_frac = r_mant[FRAC_W-1:0];
  assign bus.out_exp  = r_exp[EXP_W-1:0];
  assign bus.out_sign = r_sign;
  assign bus.out_zero = r_zero;
  assign bus.out_ovf  = r_ovf;
  assign bus.out_uf   = r_uf;

endmodule

// File: tb/tb_ieee_norm_ctrl.sv
// Directed bench for ieee_norm_ctrl; expectations switch on NORM_DENORM_EN.
module tb_ieee_norm_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;

  ieee_norm_ctrl_if bus ();

  ieee_norm_ctrl #(.MANT_W(24), .EXP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Present one operand, count edges from the accept edge until out_valid.
  task automatic send(input logic [24:0] m, input logic [7:0] e, input logic s,
                      output int l);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mant  = m;
    bus.in_exp   = e;
    bus.in_sign  = s;
    @(posedge clk);
    l = 1;
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    while (!bus.out_valid && l < 20) begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end
  endtask

  task automatic handoff(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, bus.out_zero, bus.out_ovf, bus.out_uf};
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.in_sign   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_frac",      32'(bus.out_frac),  32'd0);
    check("rst_exp",       32'(bus.out_exp),   32'd0);
    check("rst_sign",      32'(bus.out_sign),  32'd0);
    check("rst_flags",     flags(),            32'd0);
    rst = 1'b0;

    // Carry out: 1.0 x 2 -> exp+1
    send(25'h1000000, 8'd127, 1'b0, lat);
    check("carry_lat",   32'(lat),          32'd2);
    check("carry_frac",  32'(bus.out_frac), 32'h0);
    check("carry_exp",   32'(bus.out_exp),  32'd128);
    check("carry_flags", flags(),           32'd0);
    check("carry_sign",  32'(bus.out_sign), 32'd0);
    handoff("carry");

    // Already normalized, negative sign passes through
    send(25'h0C00000, 8'd130, 1'b1, lat);
    check("norm_lat",   32'(lat),          32'd2);
    check("norm_frac",  32'(bus.out_frac), 32'h400000);
    check("norm_exp",   32'(bus.out_exp),  32'd130);
    check("norm_flags", flags(),           32'd0);
    check("norm_sign",  32'(bus.out_sign), 32'd1);
    handoff("norm");

    // 15 leading zeros
    send(25'h0000100, 8'd127, 1'b0, lat);
    check("lz_lat",   32'(lat),          32'd4);
    check("lz_frac",  32'(bus.out_frac), 32'h0);
    check("lz_exp",   32'(bus.out_exp),  32'd112);
    check("lz_flags", flags(),           32'd0);
    handoff("lz");

    // Exact zero keeps sign
    send(25'h0000000, 8'd100, 1'b1, lat);
    check("zero_lat",   32'(lat),          32'd2);
    check("zero_frac",  32'(bus.out_frac), 32'h0);
    check("zero_exp",   32'(bus.out_exp),  32'd0);
    check("zero_flags", flags(),           32'b100);
    check("zero_sign",  32'(bus.out_sign), 32'd1);
    handoff("zero");

    // Carry into exponent 255 saturates
    send(25'h1800000, 8'd254, 1'b0, lat);
    check("ovf_lat",   32'(lat),          32'd2);
    check("ovf_frac",  32'(bus.out_frac), 32'h0);
    check("ovf_exp",   32'(bus.out_exp),  32'd255);
    check("ovf_flags", flags(),           32'b010);
    handoff("ovf");

    // Exponent 255 passes through unchanged
    send(25'h0C00000, 8'd255, 1'b0, lat);
    check("inf_lat",  32'(lat),          32'd2);
    check("inf_frac", 32'(bus.out_frac), 32'h400000);
    check("inf_exp",  32'(bus.out_exp),  32'd255);
    handoff("inf");

    // Underflow region
    send(25'h0000001, 8'd10, 1'b1, lat);
    check("uf_lat",  32'(lat),          32'd4);
    check("uf_exp",  32'(bus.out_exp),  32'd0);
    check("uf_sign", 32'(bus.out_sign), 32'd1);
`ifdef NORM_DENORM_EN
    check("uf_frac",  32'(bus.out_frac), 32'h000200);
    check("uf_flags", flags(),           32'b001);
`else
    check("uf_frac",  32'(bus.out_frac), 32'h0);
    check("uf_flags", flags(),           32'b101);
`endif
    handoff("uf");

    // Backpressure: 5 lz -> exp 45, frac 400000; held while in_valid is offered
    send(25'h0060000, 8'd50, 1'b0, lat);
    check("bp_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_mant  = 25'h1000000;
      bus.in_exp   = 8'd3;
      @(negedge clk);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_ready", 32'(bus.in_ready),  32'd0);
      check("bp_frac",  32'(bus.out_frac),  32'h400000);
      check("bp_exp",   32'(bus.out_exp),   32'd45);
      check("bp_flags", flags(),            32'd0);
    end
    bus.in_valid = 1'b0;
    handoff("bp");
    repeat (3) @(negedge clk);
    check("bp_no_ghost", 32'(bus.out_valid), 32'd0);

    // Reset while in SHIFT
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mant  = 25'h0000100;
    bus.in_exp   = 8'd127;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rs_pre_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rs_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rs_ready_after", 32'(bus.in_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("rs_no_valid", 32'(bus.out_valid), 32'd0);

    // Fresh op after reset behaves normally
    send(25'h0C00000, 8'd130, 1'b0, lat);
    check("post_lat",  32'(lat),          32'd2);
    check("post_frac", 32'(bus.out_frac), 32'h400000);
    check("post_exp",  32'(bus.out_exp),  32'd130);
    handoff("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
